dcache_data_sram_ctrl: RTL

Requester-side controller for the 64x128 single-port data-cache SRAM macro, sitting between the D-cache pipeline and the macro's RW port. It accepts read and masked-write requests over a valid/ready handshake and drives the macro's active-low chip-select, write-enable, mask, address and data pins. It captures read data at the correct edge and returns it through a small response buffer with backpressure. After every reset it zero-fills the array before accepting traffic.

---
 rtl/dcache_pkg.sv | 19 +
 rtl/dcache_data_sram_ctrl_if.sv | 31 +++
 rtl/dcache_resp_fifo.sv | 59 +++++
 rtl/dcache_data_sram_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants, line/mask/index typedefs and controller state encoding for
// the data-cache SRAM controller slice.
package dcache_pkg;

  localparam int DCACHE_ADDR_WIDTH = 6;
  localparam int DCACHE_DATA_WIDTH = 128;
  localparam int DCACHE_NUM_WMASKS = DCACHE_DATA_WIDTH / 8;
  localparam int DCACHE_RESP_DEPTH = 2;

  typedef logic [DCACHE_DATA_WIDTH-1:0] dcache_line_t;
  typedef logic [DCACHE_NUM_WMASKS-1:0] dcache_wmask_t;
  typedef logic [DCACHE_ADDR_WIDTH-1:0] dcache_idx_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dcache_state_e;

endpackage

// File: rtl/dcache_data_sram_ctrl_if.sv
// Request/response handshake bundle between the D-cache pipeline (master)
// and the data SRAM controller (slave).
interface dcache_data_sram_ctrl_if
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = DCACHE_DATA_WIDTH,
  parameter int NUM_WMASKS = DCACHE_NUM_WMASKS
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/dcache_resp_fifo.sv
// In-order read-response buffer; head entry is presented combinationally and
// reads as zero while the buffer is empty.
module dcache_resp_fifo
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = DCACHE_DATA_WIDTH,
  parameter int DEPTH      = DCACHE_RESP_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/dcache_data_sram_ctrl.sv
// Data-cache SRAM controller: zero-fills the macro after reset, then issues
// reads and masked writes with registered pins. Optional request counters are
// enabled by defining DCACHE_SRAM_STATS_EN.
module dcache_data_sram_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = DCACHE_DATA_WIDTH,
  parameter int NUM_WMASKS = DCACHE_NUM_WMASKS,
  parameter int RESP_DEPTH = DCACHE_RESP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  dcache_data_sram_ctrl_if.slave bus,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  init_done
`ifdef DCACHE_SRAM_STATS_EN
  ,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes
`endif
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  dcache_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  iss_rd_q, iss_rd_d;
  logic                  mac_rd_q, mac_rd_d;
`ifdef DCACHE_SRAM_STATS_EN
  logic [31:0]           stat_reads_q, stat_reads_d;
  logic [31:0]           stat_writes_q, stat_writes_d;
`endif

  logic [CW-1:0]         resp_count;
  logic [CW:0]           occupancy;
  logic                  req_ok;
  logic                  hs;
  logic                  pop;

  // Buffered responses plus reads still travelling through the macro must fit.
  assign occupancy = {1'b0, resp_count} + (CW+1)'(iss_rd_q) + (CW+1)'(mac_rd_q);
  assign req_ok    = init_done_q && (occupancy < (CW+1)'(RESP_DEPTH));
  assign hs        = bus.req_valid && req_ok;
  assign pop       = bus.resp_valid && bus.resp_ready;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = '0;
    addr_d      = addr_q;
    din_d       = din_q;
    iss_rd_d    = 1'b0;
    mac_rd_d    = iss_rd_q;
`ifdef DCACHE_SRAM_STATS_EN
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
`endif
    case (state_q)
      INIT: begin
        csb_d      = 1'b0;
        web_d      = 1'b0;
        wmask_d    = '1;
        addr_d     = init_cnt_q;
        din_d      = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // init_done lags the state by a cycle so the last zero-fill pin
        // cycle never overlaps an accepted request.
        init_done_d = 1'b1;
        if (hs) begin
          csb_d    = 1'b0;
          web_d    = ~bus.req_we;
          wmask_d  = bus.req_we ? bus.req_wmask : '0;
          addr_d   = bus.req_addr;
          din_d    = bus.req_we ? bus.req_wdata : din_q;
          iss_rd_d = ~bus.req_we;
`ifdef DCACHE_SRAM_STATS_EN
          stat_reads_d  = stat_reads_q + 32'(!bus.req_we);
          stat_writes_d = stat_writes_q + 32'(bus.req_we);
`endif
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Issue stage (pins) and macro stage (read tag) registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      iss_rd_q    <= 1'b0;
      mac_rd_q    <= 1'b0;
`ifdef DCACHE_SRAM_STATS_EN
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      iss_rd_q    <= iss_rd_d;
      mac_rd_q    <= mac_rd_d;
`ifdef DCACHE_SRAM_STATS_EN
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
`endif
    end
  end

  // Capture stage: sram_dout is only meaningful on the edge ending a read's macro cycle.
  dcache_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mac_rd_q),
    .push_data (sram_dout),
    .pop       (pop),
    .head_data (bus.resp_rdata),
    .count     (resp_count)
  );

  assign bus.req_ready  = req_ok;
  assign bus.resp_valid = (resp_count != '0);
  assign sram_csb       = csb_q;
  assign sram_web       = web_q;
  assign sram_wmask     = wmask_q;
  assign sram_addr      = addr_q;
  assign sram_din       = din_q;
  assign init_done      = init_done_q;
`ifdef DCACHE_SRAM_STATS_EN
  assign stat_reads     = stat_reads_q;
  assign stat_writes    = stat_writes_q;
`endif

endmodule
